// File: rtl/axi_portal_bridge_if.sv
// Purpose: AXI3 MAXIGP0-style bus bundle (AR/AW/W in, R/B out) between the PS master and the portal bridge.
// Latency: none (wires only).
// Backpressure: every channel is ena/rdy; a beat transfers on the cycle both are high.
// Modports: slave (bridge side), master (PS / testbench side).
interface axi_portal_bridge_if #(
    parameter int ID_W = 6
);
    logic            ar_ena;
    logic            ar_rdy;
    logic [31:0]     ar_addr;
    logic [ID_W-1:0] ar_id;
    logic [3:0]      ar_len;

    logic            aw_ena;
    logic            aw_rdy;
    logic [31:0]     aw_addr;
    logic [ID_W-1:0] aw_id;
    logic [3:0]      aw_len;

    logic            w_ena;
    logic            w_rdy;
    logic [31:0]     w_data;
    logic [ID_W-1:0] w_id;
    logic            w_last;

    logic            r_ena;
    logic            r_rdy;
    logic [31:0]     r_data;
    logic [ID_W-1:0] r_id;
    logic            r_last;
    logic [1:0]      r_resp;

    logic            b_ena;
    logic            b_rdy;
    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;

    modport slave (
        input  ar_ena, ar_addr, ar_id, ar_len,
        output ar_rdy,
        input  aw_ena, aw_addr, aw_id, aw_len,
        output aw_rdy,
        input  w_ena, w_data, w_id, w_last,
        output w_rdy,
        output r_ena, r_data, r_id, r_last, r_resp,
        input  r_rdy,
        output b_ena, b_id, b_resp,
        input  b_rdy
    );

    modport master (
        output ar_ena, ar_addr, ar_id, ar_len,
        input  ar_rdy,
        output aw_ena, aw_addr, aw_id, aw_len,
        input  aw_rdy,
        output w_ena, w_data, w_id, w_last,
        input  w_rdy,
        input  r_ena, r_data, r_id, r_last, r_resp,
        output r_rdy,
        input  b_ena, b_id, b_resp,
        output b_rdy
    );
endinterface

// File: rtl/axi_portal_bridge.sv
// Purpose: AXI3 slave bridging PS register bursts to NUM_IND indication channels and one request stream.
// Latency: R beat registered one cycle after AR accept / previous R handshake; B the cycle after the last W beat.
// Backpressure: R advances only on r_rdy; W stalls on a push beat while req_enq_rdy_i is low; B held until b_rdy.
// Ports: clk_i, rst_i (sync, active-high); axi (slave modport: AR/AW/W/R/B);
//        ind_enq_* per-channel indication push (value 32b, length 16b, rdy = channel empty);
//        req_enq_* request word out (chan, v) with comb ena; interrupt_o.
// Option: define AXI_PORTAL_ERRRESP_EN to answer unmapped beats with SLVERR (2'b10) on R and B.
module axi_portal_bridge #(
    parameter int NUM_IND   = 2,
    parameter int ID_W      = 6,
    parameter int PORTAL_ID = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    axi_portal_bridge_if.slave      axi,
    input  logic [NUM_IND-1:0]      ind_enq_ena_i,
    input  logic [32*NUM_IND-1:0]   ind_enq_v_i,
    input  logic [16*NUM_IND-1:0]   ind_enq_length_i,
    output logic [NUM_IND-1:0]      ind_enq_rdy_o,
    output logic                    req_enq_ena_o,
    output logic [2:0]              req_enq_chan_o,
    output logic [31:0]             req_enq_v_o,
    input  logic                    req_enq_rdy_i,
    output logic                    interrupt_o
);
    typedef enum logic       {RD_IDLE, RD_BURST}         rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    // Per-channel state
    logic [15:0] length_q [NUM_IND];
    logic [31:0] value_q  [NUM_IND];
    logic [NUM_IND-1:0] int_en_q;

    // Read engine
    rd_state_t       rd_state_q, rd_state_d;
    logic [9:0]      rd_hi_q;      // addr[14:5] of the burst: channel + window select
    logic [4:0]      rd_off_q;     // offset of the beat currently held in the R registers
    logic [4:0]      rd_beats_q;
    logic [4:0]      rd_k_q;       // index of the beat currently held in the R registers
    logic [ID_W-1:0] rd_id_q;
    logic            r_vld_q;
    logic            r_last_q;
    logic [31:0]     r_data_q;
    logic [1:0]      r_resp_q;

    logic            ar_fire, r_fire, rd_adv, rd_ld, rd_ld_last, rd_ld_map;
    logic [14:0]     rd_ld_a;
    logic [31:0]     rd_ld_dat;
    logic [NUM_IND-1:0] rd_clr;

    // Write engine
    wr_state_t       wr_state_q, wr_state_d;
    logic [9:0]      wr_hi_q;
    logic [4:0]      wr_off_q;
    logic [4:0]      wr_beats_q;
    logic [4:0]      wr_k_q;
    logic [ID_W-1:0] wr_id_q;
    logic            aw_fire, w_fire, w_rdy, wr_last, wr_push, wr_map;
    logic [NUM_IND-1:0] wr_ien;

    //------------------------------------------------------------------
    // Read path
    //------------------------------------------------------------------
    assign ar_fire = axi.ar_ena & (rd_state_q == RD_IDLE);
    assign r_fire  = r_vld_q & axi.r_rdy;
    assign rd_adv  = r_fire & ~r_last_q;
    // A beat is "launched" (decoded, side effects applied) when it is loaded into the R registers.
    assign rd_ld   = ar_fire | rd_adv;
    // Burst offsets wrap inside the 32-byte window; upper address bits stay fixed.
    assign rd_ld_a = ar_fire ? axi.ar_addr[14:0] : {rd_hi_q, rd_off_q + 5'd4};
    // Next beat index is k+1; it is the last when k+1 == beats-1.
    assign rd_ld_last = ar_fire ? (axi.ar_len == 4'd0) : (rd_k_q + 5'd2 == rd_beats_q);

    always_comb begin
        rd_ld_dat = '0;
        rd_ld_map = 1'b0;
        rd_clr    = '0;
        for (int c = 0; c < NUM_IND; c++) begin
            if (rd_ld_a[14:12] == 3'(c)) begin
                if (rd_ld_a[11:5] == 7'd0) begin
                    case (rd_ld_a[4:0])
                        5'h00, 5'h0C: begin rd_ld_dat = {16'd0, length_q[c]}; rd_ld_map = 1'b1; end
                        5'h04:        begin rd_ld_dat = {31'd0, int_en_q[c]}; rd_ld_map = 1'b1; end
                        5'h08:        begin rd_ld_dat = 32'd1;                rd_ld_map = 1'b1; end
                        5'h10:        begin rd_ld_dat = 32'(PORTAL_ID + c);   rd_ld_map = 1'b1; end
                        5'h14:        begin rd_ld_dat = 32'd2;                rd_ld_map = 1'b1; end
                        default:      ;
                    endcase
                end else if (rd_ld_a[4:0] == 5'h00) begin
                    rd_ld_dat = value_q[c];
                    rd_ld_map = 1'b1;
                    rd_clr[c] = rd_ld;
                end
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE:  if (axi.ar_ena)           rd_state_d = RD_BURST;
            RD_BURST: if (r_fire && r_last_q)   rd_state_d = RD_IDLE;
            default:                            rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_hi_q    <= '0;
            rd_off_q   <= '0;
            rd_beats_q <= '0;
            rd_k_q     <= '0;
            rd_id_q    <= '0;
            r_vld_q    <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_fire) begin
                rd_hi_q    <= axi.ar_addr[14:5];
                rd_beats_q <= {1'b0, axi.ar_len} + 5'd1;
                rd_k_q     <= '0;
                rd_id_q    <= axi.ar_id;
            end else if (rd_adv) begin
                rd_k_q <= rd_k_q + 5'd1;
            end
            if (rd_ld) begin
                rd_off_q <= rd_ld_a[4:0];
                r_data_q <= rd_ld_dat;
                r_last_q <= rd_ld_last;
                r_vld_q  <= 1'b1;
`ifdef AXI_PORTAL_ERRRESP_EN
                r_resp_q <= rd_ld_map ? 2'b00 : 2'b10;
`else
                r_resp_q <= 2'b00;
`endif
            end else if (r_fire) begin
                r_vld_q <= 1'b0;
            end
        end
    end

    assign axi.ar_rdy = (rd_state_q == RD_IDLE);
    assign axi.r_ena  = r_vld_q;
    assign axi.r_data = r_data_q;
    assign axi.r_id   = rd_id_q;
    assign axi.r_last = r_last_q;
    assign axi.r_resp = r_resp_q;

    //------------------------------------------------------------------
    // Write path
    //------------------------------------------------------------------
    assign aw_fire = axi.aw_ena & (wr_state_q == WR_IDLE);
    assign wr_last = (wr_k_q + 5'd1 == wr_beats_q);

    always_comb begin
        wr_push = 1'b0;
        wr_map  = 1'b0;
        wr_ien  = '0;
        for (int c = 0; c < NUM_IND; c++) begin
            if (wr_hi_q[9:7] == 3'(c) && wr_off_q == 5'h04) begin
                wr_map = 1'b1;
                if (wr_hi_q[6:0] == 7'd0) wr_ien[c] = 1'b1;
                else                      wr_push   = 1'b1;
            end
        end
    end

    // A push beat cannot complete until the request consumer can take it.
    assign w_rdy         = (wr_state_q == WR_DATA) & ~(wr_push & ~req_enq_rdy_i);
    assign w_fire        = axi.w_ena & w_rdy;
    assign req_enq_ena_o = w_fire & wr_push;
    assign req_enq_chan_o = wr_hi_q[9:7];
    assign req_enq_v_o    = axi.w_data;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (axi.aw_ena)         wr_state_d = WR_DATA;
            WR_DATA: if (w_fire && wr_last)  wr_state_d = WR_RESP;
            WR_RESP: if (axi.b_rdy)          wr_state_d = WR_IDLE;
            default:                         wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WR_IDLE;
            wr_hi_q    <= '0;
            wr_off_q   <= '0;
            wr_beats_q <= '0;
            wr_k_q     <= '0;
            wr_id_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_fire) begin
                wr_hi_q    <= axi.aw_addr[14:5];
                wr_off_q   <= axi.aw_addr[4:0];
                wr_beats_q <= {1'b0, axi.aw_len} + 5'd1;
                wr_k_q     <= '0;
                wr_id_q    <= axi.aw_id;
            end else if (w_fire) begin
                wr_off_q <= wr_off_q + 5'd4;
                wr_k_q   <= wr_k_q + 5'd1;
            end
        end
    end

`ifdef AXI_PORTAL_ERRRESP_EN
    // Sticky per burst: any unmapped beat turns the single B into SLVERR.
    logic wr_err_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)             wr_err_q <= 1'b0;
        else if (aw_fire)      wr_err_q <= 1'b0;
        else if (w_fire)       wr_err_q <= wr_err_q | ~wr_map;
    end
    assign axi.b_resp = wr_err_q ? 2'b10 : 2'b00;
    logic unused_ok;
    assign unused_ok = ^{axi.ar_addr[31:15], axi.aw_addr[31:15], axi.w_id, axi.w_last};
`else
    assign axi.b_resp = 2'b00;
    logic unused_ok;
    assign unused_ok = ^{axi.ar_addr[31:15], axi.aw_addr[31:15], axi.w_id, axi.w_last,
                         rd_ld_map, wr_map};
`endif

    assign axi.aw_rdy = (wr_state_q == WR_IDLE);
    assign axi.w_rdy  = w_rdy;
    assign axi.b_ena  = (wr_state_q == WR_RESP);
    assign axi.b_id   = wr_id_q;

    //------------------------------------------------------------------
    // Indication channels and interrupt
    //------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_IND; c++) begin
                length_q[c] <= '0;
                value_q[c]  <= '0;
            end
            int_en_q <= '0;
        end else begin
            for (int c = 0; c < NUM_IND; c++) begin
                // An enqueue into an already-empty channel wins over a same-cycle read clear.
                if (rd_clr[c]) length_q[c] <= '0;
                if (ind_enq_ena_i[c] && length_q[c] == 16'd0) begin
                    length_q[c] <= ind_enq_length_i[16*c +: 16];
                    value_q[c]  <= ind_enq_v_i[32*c +: 32];
                end
                if (w_fire && wr_ien[c]) int_en_q[c] <= axi.w_data[0];
            end
        end
    end

    always_comb begin
        interrupt_o   = 1'b0;
        ind_enq_rdy_o = '0;
        for (int c = 0; c < NUM_IND; c++) begin
            ind_enq_rdy_o[c] = (length_q[c] == 16'd0);
            interrupt_o      = interrupt_o | ((length_q[c] != 16'd0) & int_en_q[c]);
        end
    end
endmodule

// File: tb/tb_axi_portal_bridge.sv
// Purpose: directed self-checking bench for axi_portal_bridge (NUM_IND=2, ID_W=6, PORTAL_ID=5).
// Latency: inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: R/B/req ready driven explicitly per scenario.
module tb_axi_portal_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ind_ena;
    logic [63:0] ind_v;
    logic [31:0] ind_len;
    logic [1:0]  ind_rdy;
    logic        req_ena;
    logic [2:0]  req_chan;
    logic [31:0] req_v;
    logic        req_rdy;
    logic        irq;
    int          n_checks = 0;
    int          n_errors = 0;
    int          pushes;

`ifdef AXI_PORTAL_ERRRESP_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    always #5 clk = ~clk;

    axi_portal_bridge_if #(.ID_W(6)) axi ();

    axi_portal_bridge #(.NUM_IND(2), .ID_W(6), .PORTAL_ID(5)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .axi              (axi),
        .ind_enq_ena_i    (ind_ena),
        .ind_enq_v_i      (ind_v),
        .ind_enq_length_i (ind_len),
        .ind_enq_rdy_o    (ind_rdy),
        .req_enq_ena_o    (req_ena),
        .req_enq_chan_o   (req_chan),
        .req_enq_v_o      (req_v),
        .req_enq_rdy_i    (req_rdy),
        .interrupt_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        axi.ar_ena  = 1'b1;
        axi.ar_addr = addr;
        axi.ar_len  = len;
        axi.ar_id   = id;
        tick();
        axi.ar_ena  = 1'b0;
        #1;
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        axi.aw_ena  = 1'b1;
        axi.aw_addr = addr;
        axi.aw_len  = len;
        axi.aw_id   = id;
        tick();
        axi.aw_ena  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ind_ena = '0; ind_v = '0; ind_len = '0; req_rdy = 1'b1;
        axi.ar_ena = 1'b0; axi.ar_addr = '0; axi.ar_id = '0; axi.ar_len = '0;
        axi.aw_ena = 1'b0; axi.aw_addr = '0; axi.aw_id = '0; axi.aw_len = '0;
        axi.w_ena = 1'b0;  axi.w_data = '0;  axi.w_id = '0;  axi.w_last = 1'b0;
        axi.r_rdy = 1'b0;  axi.b_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); #1;

        // Reset state
        check("rst_r_ena",   32'(axi.r_ena), 32'd0);
        check("rst_b_ena",   32'(axi.b_ena), 32'd0);
        check("rst_req_ena", 32'(req_ena),   32'd0);
        check("rst_irq",     32'(irq),       32'd0);
        check("rst_ar_rdy",  32'(axi.ar_rdy), 32'd1);
        check("rst_aw_rdy",  32'(axi.aw_rdy), 32'd1);
        check("rst_ind_rdy", 32'(ind_rdy),   32'd3);

        // 1: ctrl 0x08 of channel 1 reads constant 1, single beat
        axi.r_rdy = 1'b1;
        ar_issue(32'h1008, 4'd0, 6'h2A);
        check("t1_r_ena",  32'(axi.r_ena),  32'd1);
        check("t1_data",   axi.r_data,      32'd1);
        check("t1_last",   32'(axi.r_last), 32'd1);
        check("t1_resp",   32'(axi.r_resp), 32'd0);
        check("t1_id",     32'(axi.r_id),   32'h2A);
        check("t1_ar_rdy_busy", 32'(axi.ar_rdy), 32'd0);
        tick(); #1;
        check("t1_r_done", 32'(axi.r_ena),  32'd0);
        check("t1_ar_rdy", 32'(axi.ar_rdy), 32'd1);

        // 2: load channel 1, then a dropped second enqueue, then 2-beat ctrl read
        ind_ena = 2'b10; ind_v = {32'h0000_CAFE, 32'h0}; ind_len = {16'd3, 16'd0};
        tick();
        ind_ena = 2'b00; #1;
        check("t2_ind_rdy", 32'(ind_rdy), 32'd1);
        ind_ena = 2'b10; ind_v = {32'h0000_BEEF, 32'h0}; ind_len = {16'd99, 16'd0};
        tick();
        ind_ena = 2'b00;
        ar_issue(32'h1000, 4'd1, 6'h05);
        check("t2_b0_data", axi.r_data,      32'd3);
        check("t2_b0_last", 32'(axi.r_last), 32'd0);
        check("t2_b0_id",   32'(axi.r_id),   32'h05);
        tick(); #1;
        check("t2_b1_ena",  32'(axi.r_ena),  32'd1);
        check("t2_b1_data", axi.r_data,      32'd0);
        check("t2_b1_last", 32'(axi.r_last), 32'd1);
        tick(); #1;
        check("t2_done",    32'(axi.r_ena),  32'd0);

        // 3: data-window read returns value and clears length; R held while r_rdy low
        check("t3_rdy_before", 32'(ind_rdy[1]), 32'd0);
        axi.r_rdy = 1'b0;
        ar_issue(32'h1080, 4'd0, 6'h01);
        check("t3_data",      axi.r_data,  32'h0000_CAFE);
        check("t3_rdy_after", 32'(ind_rdy), 32'd3);
        tick(); #1;
        check("t3_r_hold",    32'(axi.r_ena), 32'd1);
        axi.r_rdy = 1'b1;
        tick(); #1;
        check("t3_done",      32'(axi.r_ena), 32'd0);

        // 4: enable interrupt on ch0, enqueue -> irq, read clears -> no irq
        aw_issue(32'h0000_0004, 4'd0, 6'h03);
        axi.w_ena = 1'b1; axi.w_data = 32'd1; #1;
        check("t4_w_rdy", 32'(axi.w_rdy), 32'd1);
        tick();
        axi.w_ena = 1'b0; #1;
        check("t4_b_ena",  32'(axi.b_ena),  32'd1);
        check("t4_b_id",   32'(axi.b_id),   32'h03);
        check("t4_b_resp", 32'(axi.b_resp), 32'd0);
        check("t4_irq_empty", 32'(irq), 32'd0);
        tick(); #1;
        check("t4_b_hold", 32'(axi.b_ena),  32'd1);
        axi.b_rdy = 1'b1;
        tick();
        axi.b_rdy = 1'b0; #1;
        check("t4_b_done", 32'(axi.b_ena),  32'd0);
        check("t4_aw_rdy", 32'(axi.aw_rdy), 32'd1);
        ind_ena = 2'b01; ind_v = {32'h0, 32'h0000_1234}; ind_len = {16'd0, 16'd2};
        tick();
        ind_ena = 2'b00; #1;
        check("t4_irq_on", 32'(irq), 32'd1);
        ar_issue(32'h0080, 4'd0, 6'h04);
        check("t4_rd_data", axi.r_data, 32'h0000_1234);
        check("t4_irq_off", 32'(irq),   32'd0);
        tick();

        // 5: 4-beat write from 0x84; offsets 4,8,C,10 -> only beat 0 is a push
        req_rdy = 1'b0;
        aw_issue(32'h0000_0084, 4'd3, 6'h07);
        axi.w_ena = 1'b1; axi.w_data = 32'h0000_00A0;
        pushes = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_stall_w_rdy", 32'(axi.w_rdy), 32'd0);
            if (req_ena) pushes++;
            tick();
        end
        req_rdy = 1'b1; #1;
        check("t5_w_rdy",    32'(axi.w_rdy), 32'd1);
        check("t5_req_ena",  32'(req_ena),   32'd1);
        check("t5_req_chan", 32'(req_chan),  32'd0);
        check("t5_req_v",    req_v,          32'h0000_00A0);
        if (req_ena) pushes++;
        tick();
        for (int k = 1; k < 4; k++) begin
            axi.w_data = 32'h0000_00A0 + 32'(k); #1;
            check("t5_beat_w_rdy", 32'(axi.w_rdy), 32'd1);
            if (req_ena) pushes++;
            tick();
        end
        axi.w_ena = 1'b0; #1;
        check("t5_pushes", 32'(pushes), 32'd1);
        check("t5_b_ena",  32'(axi.b_ena),  32'd1);
        check("t5_b_id",   32'(axi.b_id),   32'h07);
        check("t5_b_resp", 32'(axi.b_resp), 32'(ERR));
        tick(); #1;
        check("t5_b_hold", 32'(axi.b_ena), 32'd1);
        axi.b_rdy = 1'b1;
        tick();
        axi.b_rdy = 1'b0; #1;
        check("t5_b_done", 32'(axi.b_ena), 32'd0);

        // 6: unmapped channel 7, then reset mid-burst
        axi.r_rdy = 1'b1;
        ar_issue(32'h7000, 4'd3, 6'h09);
        check("t6_r_ena",  32'(axi.r_ena),  32'd1);
        check("t6_data",   axi.r_data,      32'd0);
        check("t6_resp",   32'(axi.r_resp), 32'(ERR));
        rst = 1'b1;
        tick(); #1;
        check("t6_rst_r_ena",  32'(axi.r_ena),  32'd0);
        check("t6_rst_ar_rdy", 32'(axi.ar_rdy), 32'd1);
        rst = 1'b0;
        tick(); #1;
        check("t6_no_resume", 32'(axi.r_ena), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
